// File: rtl/pool_input_sender_if.sv
// Row handshake between the conv kernel array (master) and pool_input_sender (slave).
//   conv_valid : master has a row on conv_data
//   conv_ready : slave can accept a row this cycle
//   conv_last  : row is the last one of its feature map
//   conv_data  : packed row, value 0 in the LSBs
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface pool_input_sender_if #(
  parameter int unsigned INPUT_SIZE = 6,
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
);
  logic                             conv_valid;
  logic                             conv_ready;
  logic                             conv_last;
  logic [INPUT_SIZE*DATA_WIDTH-1:0] conv_data;

  modport master (
    output conv_valid,
    output conv_last,
    output conv_data,
    input  conv_ready
  );

  modport slave (
    input  conv_valid,
    input  conv_last,
    input  conv_data,
    output conv_ready
  );
endinterface

// File: rtl/pool_input_sender.sv
// Transmit side into pooling_layer_input_cache. Buffers conv rows in a small FIFO and replays
// each one as a single-cycle kernel_calc_fin strobe with data_out held until the next row,
// keeping at least GAP_CYCLES low cycles between strobes since the cache cannot stall us.
// Ports:
//   clk, rst_n       : clock (rising edge), asynchronous active-low reset
//   conv             : slave side of the conv row handshake (valid/ready/last/data)
//   kernel_calc_fin  : one-cycle strobe, data_out holds a new row
//   data_out         : row presented to the pooling cache
//   map_done         : pulses with the strobe of a map's last row
//   fifo_level       : rows currently buffered
//   row_err          : sticky, conv_last disagreed with the row count
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pool_input_sender #(
  parameter int unsigned INPUT_SIZE   = 6,
  parameter int unsigned DATA_WIDTH   = `DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned ROWS_PER_MAP = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  pool_input_sender_if.slave                 conv,
  output logic                               kernel_calc_fin,
  output logic [INPUT_SIZE*DATA_WIDTH-1:0]   data_out,
  output logic                               map_done,
  output logic [$clog2(FIFO_DEPTH):0]        fifo_level,
  output logic                               row_err
);

  localparam int unsigned W  = INPUT_SIZE * DATA_WIDTH;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned RW = (ROWS_PER_MAP > 1) ? $clog2(ROWS_PER_MAP) : 1;

  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);
  localparam logic [RW-1:0] LastIdx   = RW'(ROWS_PER_MAP - 1);
  localparam logic [GW-1:0] GapLoad   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSend, StHold} state_e;

  state_e          state_q;
  logic [W:0]      mem_q [FIFO_DEPTH];  // {last, data}
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic            ready_en_q;
  logic [GW-1:0]   gap_q;
  logic [RW-1:0]   row_q;

  logic            push, pop;
  logic            head_last;
  logic [W-1:0]    head_data;
  logic            row_at_last;

  // ready_en_q keeps conv_ready low while in reset and for the release edge.
  assign conv.conv_ready = ready_en_q & (level_q < LevelFull);
  assign push            = conv.conv_valid & conv.conv_ready;
  assign head_last       = mem_q[rd_ptr_q][W];
  assign head_data       = mem_q[rd_ptr_q][W-1:0];
  assign row_at_last     = (row_q == LastIdx);
  assign fifo_level      = level_q;

  // Pop whenever the FSM is allowed to issue a strobe this edge and a row is waiting.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      StIdle:  pop = (level_q != '0);
      StSend:  pop = (GAP_CYCLES == 0) && (level_q != '0);
      StHold:  pop = (gap_q == '0) && (level_q != '0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {conv.conv_last, conv.conv_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      kernel_calc_fin <= 1'b0;
      map_done        <= 1'b0;
      data_out        <= '0;
      gap_q           <= '0;
      row_q           <= '0;
      row_err         <= 1'b0;
    end else begin
      kernel_calc_fin <= pop;
      map_done        <= pop & head_last;

      if (pop) begin
        data_out <= head_data;
        if (head_last != row_at_last) row_err <= 1'b1;
        // Wrap on a tagged row, and also at the nominal map end so one bad tag cannot
        // desynchronise the count forever.
        if (head_last || row_at_last) row_q <= '0;
        else                          row_q <= row_q + RW'(1);
      end

      unique case (state_q)
        StIdle: begin
          if (pop) state_q <= StSend;
        end
        StSend: begin
          if (pop) begin
            state_q <= StSend;
          end else if (GAP_CYCLES > 0) begin
            gap_q   <= GapLoad;
            state_q <= StHold;
          end else begin
            state_q <= StIdle;
          end
        end
        StHold: begin
          if (gap_q == '0) state_q <= pop ? StSend : StIdle;
          else             gap_q   <= gap_q - GW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_input_sender.sv
// Self-checking bench for pool_input_sender: one instance with GAP_CYCLES=2 and one with
// GAP_CYCLES=0. Accepted rows go into a per-instance scoreboard and are compared at each strobe.
module tb_pool_input_sender;

  localparam int unsigned IS   = 6;
  localparam int unsigned DW   = 8;
  localparam int unsigned W    = IS * DW;
  localparam int unsigned ROWS = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_input_sender_if #(.INPUT_SIZE(IS), .DATA_WIDTH(DW)) if_g ();
  pool_input_sender_if #(.INPUT_SIZE(IS), .DATA_WIDTH(DW)) if_z ();

  logic         kcf_g, md_g, err_g, kcf_z, md_z, err_z;
  logic [W-1:0] dout_g, dout_z;
  logic [2:0]   lvl_g, lvl_z;

  pool_input_sender #(
    .INPUT_SIZE(IS), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .GAP_CYCLES(2), .ROWS_PER_MAP(ROWS)
  ) dut_g (
    .clk(clk), .rst_n(rst_n), .conv(if_g), .kernel_calc_fin(kcf_g), .data_out(dout_g),
    .map_done(md_g), .fifo_level(lvl_g), .row_err(err_g)
  );

  pool_input_sender #(
    .INPUT_SIZE(IS), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .GAP_CYCLES(0), .ROWS_PER_MAP(ROWS)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .conv(if_z), .kernel_calc_fin(kcf_z), .data_out(dout_z),
    .map_done(md_z), .fifo_level(lvl_z), .row_err(err_z)
  );

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
    logic         err;
  } ent_t;

  ent_t sb_g[$], sb_z[$];
  int   st_g[$], st_z[$];
  int   checks = 0, errors = 0, cyc = 0;
  int   mcnt_g = 0, mcnt_z = 0;
  logic merr_g = 1'b0, merr_z = 1'b0;
  int   md_cnt_g = 0;
  bit   acc_g, acc_z;
  int   w;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] row(input int base);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < IS; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  // Reference row counting: expected sticky error after each row, in arrival order.
  task automatic model_push(input int sel, input logic last, input logic [W-1:0] data);
    int   c;
    logic e;
    ent_t en;
    c = (sel == 0) ? mcnt_g : mcnt_z;
    e = (sel == 0) ? merr_g : merr_z;
    if (last != (c == ROWS - 1)) e = 1'b1;
    c = (last || c == ROWS - 1) ? 0 : c + 1;
    en = '{last: last, data: data, err: e};
    if (sel == 0) begin mcnt_g = c; merr_g = e; sb_g.push_back(en); end
    else          begin mcnt_z = c; merr_z = e; sb_z.push_back(en); end
  endtask

  task automatic mon(input int sel, input logic kcf, input logic md, input logic [W-1:0] d,
                     input logic err);
    ent_t en;
    if (sel == 0 && md) md_cnt_g++;
    if (kcf) begin
      if (sel == 0) st_g.push_back(cyc);
      else          st_z.push_back(cyc);
      if ((sel == 0 && sb_g.size() == 0) || (sel == 1 && sb_z.size() == 0)) begin
        check("extra_strobe", kcf, 0);
      end else begin
        en = (sel == 0) ? sb_g.pop_front() : sb_z.pop_front();
        check(sel == 0 ? "g_data" : "z_data", d, en.data);
        check(sel == 0 ? "g_map_done" : "z_map_done", md, en.last);
        check(sel == 0 ? "g_row_err" : "z_row_err", err, en.err);
      end
    end else if (md) begin
      check("map_done_without_strobe", md, 0);
    end
  endtask

  // Inputs are driven at the falling edge; the rising edge inside this step consumes them.
  task automatic step();
    acc_g = if_g.conv_valid & if_g.conv_ready;
    acc_z = if_z.conv_valid & if_z.conv_ready;
    if (acc_g) model_push(0, if_g.conv_last, if_g.conv_data);
    if (acc_z) model_push(1, if_z.conv_last, if_z.conv_data);
    @(negedge clk);
    cyc++;
    mon(0, kcf_g, md_g, dout_g, err_g);
    mon(1, kcf_z, md_z, dout_z, err_z);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_row(input int sel, input logic [W-1:0] d, input logic last,
                          output int waits);
    bit acc;
    if (sel == 0) begin if_g.conv_valid = 1'b1; if_g.conv_data = d; if_g.conv_last = last; end
    else          begin if_z.conv_valid = 1'b1; if_z.conv_data = d; if_z.conv_last = last; end
    waits = 0;
    do begin
      step();
      waits++;
      acc = (sel == 0) ? acc_g : acc_z;
    end while (!acc && waits < 50);
    if (!acc) check("send_accept", acc, 1);
    if (sel == 0) if_g.conv_valid = 1'b0;
    else          if_z.conv_valid = 1'b0;
  endtask

  task automatic clear_model();
    sb_g.delete(); sb_z.delete();
    mcnt_g = 0; mcnt_z = 0; merr_g = 1'b0; merr_z = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    if_g.conv_valid = 1'b0; if_g.conv_last = 1'b0; if_g.conv_data = '0;
    if_z.conv_valid = 1'b0; if_z.conv_last = 1'b0; if_z.conv_data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: reset mid-stream with three rows buffered
    for (int i = 0; i < 4; i++) send_row(0, row(16 + 16 * i), 1'b0, w);
    check("t1_level_before", lvl_g, 3);
    rst_n = 1'b0;
    #1;
    check("t1_rst_kcf", kcf_g, 0);
    check("t1_rst_data", dout_g, 0);
    check("t1_rst_map_done", md_g, 0);
    check("t1_rst_level", lvl_g, 0);
    check("t1_rst_row_err", err_g, 0);
    check("t1_rst_ready", if_g.conv_ready, 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t1_ready_after", if_g.conv_ready, 1);
    check("t1_level_after", lvl_g, 0);
    idle(10);

    // 2: single-row latency and hold
    send_row(0, row(1), 1'b0, w);
    check("t2_no_strobe_yet", kcf_g, 0);
    step();
    check("t2_strobe", kcf_g, 1);
    check("t2_data", dout_g, row(1));
    step();
    check("t2_strobe_low", kcf_g, 0);
    idle(3);
    check("t2_data_held", dout_g, row(1));

    // 3: fill to full, hold off the extra row, 3-cycle strobe spacing
    st_g.delete();
    for (int i = 0; i < 6; i++) send_row(0, row(32 + 8 * i), 1'b0, w);
    check("t3_level_full", lvl_g, 4);
    check("t3_ready_full", if_g.conv_ready, 0);
    send_row(0, row(96), 1'b0, w);
    check("t3_hold_off_cycles", w, 3);
    idle(30);
    check("t3_strobe_count", st_g.size(), 7);
    for (int i = 1; i < st_g.size(); i++) check("t3_strobe_gap", st_g[i] - st_g[i-1], 3);
    check("t3_drained", sb_g.size(), 0);

    // 4: zero-gap instance streams back-to-back
    st_z.delete();
    for (int i = 0; i < 4; i++) send_row(1, row(160 + 8 * i), 1'b0, w);
    idle(8);
    check("t4_strobe_count", st_z.size(), 4);
    for (int i = 1; i < st_z.size(); i++) check("t4_strobe_gap", st_z[i] - st_z[i-1], 1);
    check("t4_drained", sb_z.size(), 0);

    // 5: two clean maps
    do_reset();
    md_cnt_g = 0;
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 6; i++) send_row(0, row(64 * m + 8 * i), i == 5, w);
    idle(30);
    check("t5_map_done_count", md_cnt_g, 2);
    check("t5_row_err", err_g, 0);
    check("t5_drained", sb_g.size(), 0);

    // 6: early conv_last, then a clean map
    md_cnt_g = 0;
    for (int i = 0; i < 4; i++) send_row(0, row(128 + 8 * i), i == 3, w);
    idle(15);
    check("t6_row_err_set", err_g, 1);
    for (int i = 0; i < 6; i++) send_row(0, row(200 + 8 * i), i == 5, w);
    idle(30);
    check("t6_row_err_sticky", err_g, 1);
    check("t6_map_done_count", md_cnt_g, 2);
    check("t6_drained", sb_g.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
